// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use interlock, taken-branch squash,
// data-memory freeze, saturating statistics and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mem_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LOAD_USE = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  stall_count_q;
    logic [CNT_W-1:0]  flush_count_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_timeout_q;

    logic mstall;
    logic lu;
    logic taken_act;

    assign mstall = mem_req & ~mem_ready;

    // LOAD_USE blocks re-detection: the dependent instruction is still in ID for one more cycle.
    assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) && (state_q != LOAD_USE) &&
                ((id_uses_rs1 && (id_rs1 == id_ex_rd)) || (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // A taken branch held during a memory freeze is acted on in the release cycle.
    assign taken_act = ex_mem_taken & ~mstall;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            if (mstall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end else if (ex_mem_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = RUN;
        if (mstall) begin
            state_d = MEM_WAIT;
        end else if (!ex_mem_taken && lu) begin
            state_d = LOAD_USE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (taken_act && (flush_count_q != {CNT_W{1'b1}})) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
            if (mstall) begin
                if (wait_cnt_q != {WAIT_W{1'b1}}) begin
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                end
                if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    mem_timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, two parameterisations
// driven in lockstep and compared against an event-history reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic       ex_mem_taken, mem_req, mem_ready;

    logic       pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a;
    logic       if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, mem_timeout_a;
    logic [1:0] state_a;
    logic [15:0] stall_count_a, flush_count_a;

    logic       pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b;
    logic       if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, mem_timeout_b;
    logic [1:0] state_b;
    logic [1:0] stall_count_b, flush_count_b;

    int tests = 0;
    int fails = 0;

    // Reference model: what happened in the previous cycle (0 normal, 1 load-use stall, 2 mem stall).
    int     last_kind = 0;
    longint stall_n   = 0;
    longint flush_n   = 0;
    int     run_len   = 0;
    bit     to_a      = 0;
    bit     to_b      = 0;
    bit     m_valid   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .ex_mem_taken(ex_mem_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .if_id_write(if_id_write_a), .id_ex_write(id_ex_write_a),
        .ex_mem_write(ex_mem_write_a), .if_id_flush(if_id_flush_a),
        .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a), .state(state_a),
        .stall_count(stall_count_a), .flush_count(flush_count_a), .mem_timeout(mem_timeout_a)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .ex_mem_taken(ex_mem_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .id_ex_write(id_ex_write_b),
        .ex_mem_write(ex_mem_write_b), .if_id_flush(if_id_flush_b),
        .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b), .state(state_b),
        .stall_count(stall_count_b), .flush_count(flush_count_b), .mem_timeout(mem_timeout_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input bit mr, input int rd, input bit tk, input bit mq, input bit my);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_mem_read = mr; id_ex_rd = 5'(rd); ex_mem_taken = tk;
        mem_req = mq; mem_ready = my;
    endtask

    // Checks one cycle against the model, then advances through the clock edge.
    task automatic cycle();
        bit ms, hz, tk;
        logic [6:0] ectl;
        #1;
        ms = mem_req && !mem_ready;
        tk = ex_mem_taken;
        hz = id_ex_mem_read && (id_ex_rd != 0) && (last_kind != 1) &&
             ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
        if (reset)   ectl = 7'b1111_000;
        else if (ms) ectl = 7'b0000_000;
        else if (tk) ectl = 7'b1111_111;
        else if (hz) ectl = 7'b0011_010;
        else         ectl = 7'b1111_000;
        check("ctrl_a", {pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a,
                         if_id_flush_a, id_ex_flush_a, ex_mem_flush_a}, ectl);
        check("ctrl_b", {pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b,
                         if_id_flush_b, id_ex_flush_b, ex_mem_flush_b}, ectl);
        if (m_valid) begin
            check("state_a", state_a, last_kind);
            check("state_b", state_b, last_kind);
            check("stall_a", stall_count_a, sat(stall_n, 65535));
            check("stall_b", stall_count_b, sat(stall_n, 3));
            check("flush_a", flush_count_a, sat(flush_n, 65535));
            check("flush_b", flush_count_b, sat(flush_n, 3));
            check("timeout_a", mem_timeout_a, to_a);
            check("timeout_b", mem_timeout_b, to_b);
        end
        if (reset) begin
            last_kind = 0; stall_n = 0; flush_n = 0; run_len = 0;
            to_a = 0; to_b = 0; m_valid = 1;
        end else begin
            if (ectl[6] == 1'b0) stall_n++;
            if (tk && !ms) flush_n++;
            if (ms) begin
                run_len++;
                if (run_len >= 64) to_a = 1;
                if (run_len >= 4) to_b = 1;
            end else begin
                run_len = 0;
            end
            last_kind = ms ? 2 : (tk ? 0 : (hz ? 1 : 0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;

        // Load-use on rs1: one stall, then LOAD_USE suppresses re-detection.
        set_in(5, 1, 1, 0, 1, 5, 0, 0, 0);
        cycle();
        check("lu_state", state_a, 1);
        cycle();
        check("lu_stall_cnt", stall_count_a, 1);

        // x0 destination and unused rs2 never stall.
        do_reset();
        set_in(0, 0, 1, 1, 1, 0, 0, 0, 0);
        cycle();
        set_in(3, 7, 1, 0, 1, 7, 0, 0, 0);
        cycle();
        check("x0_unused_stall", stall_count_a, 0);

        // Taken wins over a load-use hazard.
        do_reset();
        set_in(5, 5, 1, 1, 1, 5, 1, 0, 0);
        cycle();
        check("tk_state", state_a, 0);
        check("tk_flush_cnt", flush_count_a, 1);
        check("tk_stall_cnt", stall_count_a, 0);

        // Three-cycle memory wait then release.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cycle();
        check("mw_state", state_a, 2);
        mem_ready = 1'b1;
        cycle();
        check("mw_stall_cnt", stall_count_a, 3);
        check("mw_timeout", mem_timeout_b, 0);

        // Timeout on the small instance with a taken branch held during the freeze.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (3) cycle();
        check("to_before", mem_timeout_b, 0);
        cycle();
        check("to_set", mem_timeout_b, 1);
        repeat (2) cycle();
        check("to_sticky", mem_timeout_b, 1);
        check("to_no_flush_yet", flush_count_a, 0);
        mem_ready = 1'b1;
        cycle();
        check("to_release_flush", flush_count_a, 1);
        mem_req = 1'b0;
        cycle();
        check("to_still_set", mem_timeout_b, 1);

        // Saturation of the 2-bit counter, then reset in the middle of a memory wait.
        do_reset();
        set_in(2, 0, 1, 0, 1, 2, 0, 0, 0);
        repeat (10) cycle();
        check("sat_stall_b", stall_count_b, 3);
        check("sat_stall_a", stall_count_a, 5);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_state", state_a, 0);
        check("rst_stall", stall_count_b, 0);
        check("rst_flush", flush_count_a, 0);
        check("rst_timeout", mem_timeout_a, 0);
        cycle();

        // Default-sized timeout: 64 stalled edges.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (63) cycle();
        check("to64_before", mem_timeout_a, 0);
        cycle();
        check("to64_set", mem_timeout_a, 1);
        mem_ready = 1'b1;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                   $urandom_range(0, 3), ($urandom_range(0, 6) == 0),
                   ($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1));
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
